prog_ram_loader: RTL and testbench

Writable 16×8 instruction memory for the 4-bit CPU, replacing the fixed program store. The CPU fetch side sees the same asynchronous read port: a 4-bit address in and an 8-bit instruction out. A byte-wide valid/ready load port lets a host write a new program while the block holds the CPU. After reset the memory holds the default 1+2+…+N summation program, so the CPU runs without any host.

---
 rtl/prog_ram_loader.sv | 160 ++++++++++++++++
 tb/tb_prog_ram_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_ram_loader.sv
// prog_ram_loader: writable 16x8 instruction memory for the 4-bit CPU.
//
// The CPU fetch side gets an asynchronous read port (A -> Out). A host can
// replace the program through a byte-wide valid/ready load port. The CPU is
// held in reset while a load is in progress. If the host ends the load early,
// the rest of the memory is zero-filled. After reset the memory holds the
// default 1+2+...+N summation program.
//
// Ports:
//   clk       in   single clock, rising edge
//   n_reset   in   asynchronous active-low reset
//   A         in   [3:0] CPU fetch address
//   Out       out  [7:0] mem[A], combinational
//   load_req  in   start a program load (honoured only in RUN)
//   load_end  in   host ends the load early (honoured only in LOAD)
//   wr_valid  in   host byte valid
//   wr_data   in   [7:0] host instruction byte
//   wr_ready  out  block accepts a byte this cycle (registered, LOAD only)
//   cpu_hold  out  hold the CPU in reset (registered, LOAD and CLEAR)
//   loaded    out  sticky: a load has completed since the last load_req/reset
//   ptr       out  [3:0] next write address
module prog_ram_loader (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] A,
  output logic [7:0] Out,
  input  logic       load_req,
  input  logic       load_end,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       cpu_hold,
  output logic       loaded,
  output logic [3:0] ptr
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StClear = 2'd2;

  localparam logic [3:0] LastAddr = 4'd15;

  // Default program image restored on every reset.
  function automatic logic [7:0] default_word(input logic [3:0] addr);
    logic [7:0] w;
    case (addr)
      4'd0:    w = 8'h30;
      4'd1:    w = 8'h30;
      4'd2:    w = 8'h60;
      4'd3:    w = 8'hC0;
      4'd4:    w = 8'h5F;
      4'd5:    w = 8'hF3;
      4'd6:    w = 8'h80;
      4'd7:    w = 8'hA0;
      default: w = 8'h00;
    endcase
    return w;
  endfunction

  logic [1:0] state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic       loaded_q, loaded_d;
  logic       wr_ready_q;
  logic       cpu_hold_q;
  logic [7:0] mem_q [16];

  logic       xfer;
  logic       mem_we;
  logic [7:0] mem_wdata;

  assign xfer = wr_valid & wr_ready_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    loaded_d  = loaded_q;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (state_q)
      StRun: begin
        if (load_req) begin
          state_d  = StLoad;
          ptr_d    = 4'd0;
          loaded_d = 1'b0;
        end
      end
      StLoad: begin
        if (xfer) begin
          mem_we    = 1'b1;
          mem_wdata = wr_data;
          // The last address ends the load even when load_end is also high:
          // there is nothing left to clear.
          if (ptr_q == LastAddr) begin
            state_d  = StRun;
            ptr_d    = 4'd0;
            loaded_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 4'd1;
            if (load_end) begin
              state_d = StClear;
            end
          end
        end else if (load_end) begin
          state_d = StClear;
        end
      end
      StClear: begin
        // Zero-fill the tail so stale program bytes never survive a short load.
        mem_we    = 1'b1;
        mem_wdata = 8'h00;
        if (ptr_q == LastAddr) begin
          state_d  = StRun;
          ptr_d    = 4'd0;
          loaded_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end
      default: begin
        state_d = StRun;
        ptr_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= StRun;
      ptr_q      <= 4'd0;
      loaded_q   <= 1'b0;
      wr_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      loaded_q   <= loaded_d;
      // Registered from the next state so both flags change on the same edge
      // that changes the state.
      wr_ready_q <= (state_d == StLoad);
      cpu_hold_q <= (state_d != StRun);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= default_word(4'(i));
      end
    end else if (mem_we) begin
      mem_q[ptr_q] <= mem_wdata;
    end
  end

  assign Out      = mem_q[A];
  assign wr_ready = wr_ready_q;
  assign cpu_hold = cpu_hold_q;
  assign loaded   = loaded_q;
  assign ptr      = ptr_q;

endmodule

// File: tb/tb_prog_ram_loader.sv
// Self-checking bench for prog_ram_loader: directed scenarios followed by
// random traffic, all compared against a transaction-level memory model.
module tb_prog_ram_loader;

  logic       clk;
  logic       n_reset;
  logic [3:0] A;
  logic [7:0] Out;
  logic       load_req;
  logic       load_end;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       cpu_hold;
  logic       loaded;
  logic [3:0] ptr;

  prog_ram_loader dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .A        (A),
    .Out      (Out),
    .load_req (load_req),
    .load_end (load_end),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .cpu_hold (cpu_hold),
    .loaded   (loaded),
    .ptr      (ptr)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int checks;
  int failures;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: memory image, next write address, and whether the host
  // is currently streaming bytes, the tail is being zero-filled, or the CPU
  // owns the memory.
  logic [7:0] m [16];
  int         p;
  bit         hosting;
  bit         zeroing;
  bit         done_flag;
  int         hold_cycles;
  int         clear_cycles;

  task automatic model_reset();
    logic [7:0] img [8];
    img = '{8'h30, 8'h30, 8'h60, 8'hC0, 8'h5F, 8'hF3, 8'h80, 8'hA0};
    for (int i = 0; i < 16; i++) m[i] = (i < 8) ? img[i] : 8'h00;
    p = 0;
    hosting = 1'b0;
    zeroing = 1'b0;
    done_flag = 1'b0;
  endtask

  task automatic finish_load();
    hosting = 1'b0;
    zeroing = 1'b0;
    done_flag = 1'b1;
    p = 0;
  endtask

  task automatic model_step(input bit lr, input bit le, input bit wv, input logic [7:0] wd);
    if (zeroing) begin
      m[p] = 8'h00;
      if (p == 15) finish_load();
      else p = p + 1;
    end else if (hosting) begin
      if (wv) begin
        m[p] = wd;
        if (p == 15) finish_load();
        else begin
          p = p + 1;
          if (le) begin
            hosting = 1'b0;
            zeroing = 1'b1;
          end
        end
      end else if (le) begin
        hosting = 1'b0;
        zeroing = 1'b1;
      end
    end else if (lr) begin
      hosting = 1'b1;
      p = 0;
      done_flag = 1'b0;
    end
  endtask

  task automatic scan_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      A = 4'(a);
      #1;
      check_eq(tag, int'(Out), int'(m[a]));
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs, let the rising
  // edge happen, then advance the model with the same inputs.
  task automatic cycle(input bit lr, input bit le, input bit wv, input logic [7:0] wd,
                       input bit scan);
    @(negedge clk);
    load_req = lr;
    load_end = le;
    wr_valid = wv;
    wr_data  = wd;
    A        = 4'($urandom);
    #1;
    check_eq("out", int'(Out), int'(m[A]));
    check_eq("ptr", int'(ptr), p);
    check_eq("wr_ready", int'(wr_ready), int'(hosting));
    check_eq("cpu_hold", int'(cpu_hold), int'(hosting | zeroing));
    check_eq("loaded", int'(loaded), int'(done_flag));
    if (cpu_hold) hold_cycles++;
    if (cpu_hold && !wr_ready) clear_cycles++;
    if (scan) scan_mem("mem_scan");
    @(posedge clk);
    model_step(lr, le, wv, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] def_img [8];
    checks = 0;
    failures = 0;
    n_reset = 1'b0;
    load_req = 1'b0;
    load_end = 1'b0;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    A = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;

    // Reset state against the literal default program.
    def_img = '{8'h30, 8'h30, 8'h60, 8'hC0, 8'h5F, 8'hF3, 8'h80, 8'hA0};
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      A = 4'(a);
      #1;
      check_eq("rst_mem", int'(Out), (a < 8) ? int'(def_img[a]) : 0);
    end
    check_eq("rst_hold", int'(cpu_hold), 0);
    check_eq("rst_ready", int'(wr_ready), 0);
    check_eq("rst_loaded", int'(loaded), 0);
    @(posedge clk);

    // Full back-to-back load of 01..10.
    hold_cycles = 0;
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1, 8'(i + 1), 1'b0);
    idle(2);
    check_eq("full_hold_cycles", hold_cycles, 16);
    check_eq("full_loaded", int'(loaded), 1);
    check_eq("full_ptr", int'(ptr), 0);
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      A = 4'(a);
      #1;
      check_eq("full_mem", int'(Out), a + 1);
    end
    @(posedge clk);

    // Gapped load AA, idle, BB, then early end -> 14 clear cycles.
    clear_cycles = 0;
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'hBB, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(16);
    check_eq("gap_clear_cycles", clear_cycles, 14);
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      A = 4'(a);
      #1;
      check_eq("gap_mem", int'(Out), (a == 0) ? 'hAA : (a == 1) ? 'hBB : 0);
    end
    @(posedge clk);

    // load_end with a transfer at ptr=3: byte written, clear from 4.
    clear_cycles = 0;
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    idle(14);
    check_eq("end3_clear_cycles", clear_cycles, 12);
    A = 4'd3;
    #1;
    check_eq("end3_mem3", int'(Out), 'h77);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // load_end with a transfer at ptr=15: straight to RUN.
    clear_cycles = 0;
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
    @(negedge clk);
    #1;
    check_eq("end15_hold", int'(cpu_hold), 0);
    check_eq("end15_loaded", int'(loaded), 1);
    A = 4'd15;
    #1;
    check_eq("end15_mem15", int'(Out), 'hEE);
    @(posedge clk);
    idle(2);
    check_eq("end15_clear_cycles", clear_cycles, 0);

    // Ignored inputs in RUN: wr_valid FF and load_end.
    cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("run_loaded_kept", int'(loaded), 1);

    // load_req during LOAD must not reset ptr.
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    check_eq("lr_in_load_ptr", int'(ptr), 2);
    @(posedge clk);

    // Reset mid-load after 5 bytes (3 more on top of the 2 above).
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    @(negedge clk);
    load_req = 1'b0;
    wr_valid = 1'b0;
    load_end = 1'b0;
    #2;
    n_reset = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_hold", int'(cpu_hold), 0);
    check_eq("mid_rst_ready", int'(wr_ready), 0);
    check_eq("mid_rst_loaded", int'(loaded), 0);
    check_eq("mid_rst_ptr", int'(ptr), 0);
    scan_mem("mid_rst_mem");
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 9) < 7), 8'($urandom), (i % 97 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
